// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler: FSM states, opcodes, datapath width.
package alu_sched_pkg;

    localparam int unsigned ALU_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping at N.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        logic [IW-1:0] sel;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        sel     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel = IW'((32'(ptr) + i) % N);
            if (!any && req[sel]) begin
                any      = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/alu_8bit_scheduler.sv
// Shares one 8-bit ALU among NREQ requesters: round-robin launch, fixed-latency capture,
// tagged response with valid/ready backpressure.
module alu_8bit_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [ALU_W*NREQ-1:0]   req_a,
    input  logic [ALU_W*NREQ-1:0]   req_b,
    input  logic [2*NREQ-1:0]       req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [ALU_W-1:0]        rsp_result,
    output logic                    rsp_carry,
    output logic                    rsp_zero,
    output logic                    rsp_overflow,
    output logic [ALU_W-1:0]        alu_a,
    output logic [ALU_W-1:0]        alu_b,
    output logic [1:0]              alu_op,
    input  logic [ALU_W-1:0]        alu_result,
    input  logic                    alu_carry,
    input  logic                    alu_zero,
    input  logic                    alu_overflow,
    output logic                    busy,
    output logic [15:0]             op_count
);

    localparam int unsigned IW = $clog2(NREQ);

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [1:0]       wcnt_q, wcnt_d;
    logic [ALU_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]    rsp_id_q, rsp_id_d;
    logic [ALU_W-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_overflow_q, rsp_overflow_d;
    logic [15:0]      op_count_q, op_count_d;

    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_any;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    // Gated by rst_n so no grant is offered while the registers are held in reset.
    assign req_ready = (rst_n && state_q == IDLE) ? gnt : '0;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        wcnt_d         = wcnt_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_overflow_d = rsp_overflow_q;
        op_count_d     = op_count_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    alu_a_d  = req_a[{gnt_idx, 3'b000} +: ALU_W];
                    alu_b_d  = req_b[{gnt_idx, 3'b000} +: ALU_W];
                    alu_op_d = req_op[{gnt_idx, 1'b0} +: 2];
                    rsp_id_d = gnt_idx;
                    ptr_d    = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
                    wcnt_d   = 2'(ALU_LAT - 1);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q != 2'd0) begin
                    wcnt_d = wcnt_q - 2'd1;
                end else begin
                    rsp_result_d   = alu_result;
                    rsp_carry_d    = alu_carry;
                    rsp_zero_d     = alu_zero;
                    rsp_overflow_d = alu_overflow;
                    rsp_valid_d    = 1'b1;
                    state_d        = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            wcnt_q         <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_result_q   <= '0;
            rsp_carry_q    <= 1'b0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            op_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            wcnt_q         <= wcnt_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_overflow_q <= rsp_overflow_d;
            op_count_q     <= op_count_d;
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_overflow = rsp_overflow_q;
    assign busy         = (state_q != IDLE);
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_8bit_scheduler.sv
// Scoreboard bench for alu_8bit_scheduler: reference model predicts grants, timing and responses.
module tb_alu_8bit_scheduler;
    import alu_sched_pkg::*;

    localparam int N    = 4;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       v;
    } alu_res_t;

    typedef struct {
        int       id;
        alu_res_t res;
    } exp_t;

    function automatic alu_res_t alu_ref(logic [7:0] a, logic [7:0] b, logic [1:0] op);
        alu_res_t   o;
        logic [8:0] s;
        o = '0;
        case (op)
            OP_ADD: begin
                s   = {1'b0, a} + {1'b0, b};
                o.r = s[7:0];
                o.c = s[8];
                o.v = (a[7] == b[7]) && (o.r[7] != a[7]);
            end
            OP_SUB: begin
                s   = {1'b0, a} + {1'b0, ~b} + 9'd1;
                o.r = s[7:0];
                o.c = s[8];
                o.v = (a[7] != b[7]) && (o.r[7] != a[7]);
            end
            OP_AND:  o.r = a & b;
            default: o.r = a | b;
        endcase
        o.z = (o.r == 8'd0);
        return o;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(string name, int unsigned got, int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- main DUT (ALU_LAT = 1) ----------------
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready;
    logic [8*N-1:0] req_a, req_b;
    logic [2*N-1:0] req_op;
    logic           rsp_valid, rsp_ready;
    logic [1:0]     rsp_id;
    logic [7:0]     rsp_result, alu_a, alu_b;
    logic           rsp_carry, rsp_zero, rsp_overflow, busy;
    logic [1:0]     alu_op;
    logic [15:0]    op_count;
    alu_res_t       alu_o;

    assign alu_o = alu_ref(alu_a, alu_b, alu_op);

    alu_8bit_scheduler #(.NREQ(N), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_overflow(rsp_overflow),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_o.r), .alu_carry(alu_o.c), .alu_zero(alu_o.z),
        .alu_overflow(alu_o.v),
        .busy(busy), .op_count(op_count)
    );

    // ---------------- second DUT (ALU_LAT = 3) for reset-in-WAIT ----------------
    logic           rst3_n;
    logic [N-1:0]   v3, rdy3;
    logic [8*N-1:0] a3, b3;
    logic [2*N-1:0] op3;
    logic           rsp3_valid, rsp3_ready;
    logic [1:0]     rsp3_id;
    logic [7:0]     rsp3_result, alu3_a, alu3_b;
    logic           rsp3_carry, rsp3_zero, rsp3_overflow, busy3;
    logic [1:0]     alu3_op;
    logic [15:0]    op_count3;
    alu_res_t       alu3_o;

    assign alu3_o = alu_ref(alu3_a, alu3_b, alu3_op);

    alu_8bit_scheduler #(.NREQ(N), .ALU_LAT(LAT3)) dut3 (
        .clk(clk), .rst_n(rst3_n),
        .req_valid(v3), .req_ready(rdy3),
        .req_a(a3), .req_b(b3), .req_op(op3),
        .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready), .rsp_id(rsp3_id),
        .rsp_result(rsp3_result), .rsp_carry(rsp3_carry), .rsp_zero(rsp3_zero),
        .rsp_overflow(rsp3_overflow),
        .alu_a(alu3_a), .alu_b(alu3_b), .alu_op(alu3_op),
        .alu_result(alu3_o.r), .alu_carry(alu3_o.c), .alu_zero(alu3_o.z),
        .alu_overflow(alu3_o.v),
        .busy(busy3), .op_count(op_count3)
    );

    // ---------------- reference model + monitor (main DUT) ----------------
    exp_t        q[$];
    int          rr_ids[$];
    bit          mbusy = 1'b0;
    int          mptr = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          last_acc = -1;
    bit          rr_mode = 1'b0;
    logic [15:0] exp_cnt = '0;

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int           g;
        int           s;
        bit           exp_rv;
        exp_t         e;
        cyc++;
        if (!rst_n) begin
            mbusy   = 1'b0;
            mptr    = 0;
            exp_cnt = '0;
            q.delete();
        end else begin
            exp_rdy = '0;
            g       = -1;
            if (!mbusy) begin
                for (int k = 0; k < N; k++) begin
                    s = (mptr + k) % N;
                    if (g < 0 && req_valid[s]) begin
                        g          = s;
                        exp_rdy[s] = 1'b1;
                    end
                end
            end
            exp_rv = mbusy && (cyc >= acc_cyc + LAT + 1);
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("busy", 32'(busy), 32'(mbusy));
            check("op_count", 32'(op_count), 32'(exp_cnt));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv && q.size() > 0) begin
                check("rsp_id", 32'(rsp_id), 32'(q[0].id));
                check("rsp_result", 32'(rsp_result), 32'(q[0].res.r));
                check("rsp_flags", 32'({rsp_carry, rsp_zero, rsp_overflow}),
                      32'({q[0].res.c, q[0].res.z, q[0].res.v}));
            end
            if (g >= 0) begin
                e.id  = g;
                e.res = alu_ref(req_a[8*g +: 8], req_b[8*g +: 8], req_op[2*g +: 2]);
                q.push_back(e);
                if (rr_mode && last_acc >= 0)
                    check("accept_spacing", 32'(cyc - last_acc), 32'(LAT + 2));
                last_acc = cyc;
                acc_cyc  = cyc;
                mbusy    = 1'b1;
                mptr     = (g + 1) % N;
            end
            if (exp_rv && rsp_ready) begin
                if (rr_mode) begin
                    rr_ids.push_back(int'(rsp_id));
                    if (rr_ids.size() >= 5) rr_mode = 1'b0;
                end
                if (q.size() > 0) void'(q.pop_front());
                mbusy = 1'b0;
                exp_cnt++;
            end
        end
    end

    // ---------------- requester driver ----------------
    logic       pend [N];
    logic [7:0] va [N];
    logic [7:0] vb [N];
    logic [1:0] vo [N];
    bit         rand_en  = 1'b0;
    bit         rand_rdy = 1'b0;
    int         rand_pct = 0;

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = pend[i];
            req_a[8*i +: 8]   = va[i];
            req_b[8*i +: 8]   = vb[i];
            req_op[2*i +: 2]  = vo[i];
        end
    endtask

    task automatic new_req(int i, logic [7:0] a, logic [7:0] b, logic [1:0] op);
        pend[i] = 1'b1;
        va[i]   = a;
        vb[i]   = b;
        vo[i]   = op;
    endtask

    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) pend[i] = 1'b0;
        if (rand_en)
            for (int i = 0; i < N; i++)
                if (!pend[i] && int'($urandom_range(99)) < rand_pct)
                    new_req(i, 8'($urandom), 8'($urandom), 2'($urandom));
        if (rand_rdy) rsp_ready = ($urandom_range(99) < 70);
        drive_inputs();
    endtask

    function automatic bit any_pend();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_until_quiet(int max);
        int n = 0;
        while ((any_pend() || busy || rsp_valid) && n < max) begin
            step();
            n++;
        end
        check("quiet_timeout", 32'(n < max), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          exp_seq[5];
        alu_res_t    r3;
        exp_seq = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            va[i]   = 8'h11 * 8'(i + 1);
            vb[i]   = 8'h0F;
            vo[i]   = OP_ADD;
        end
        rst_n = 1'b0; rst3_n = 1'b0;
        rsp_ready = 1'b1; rsp3_ready = 1'b1;
        v3 = '0; a3 = '0; b3 = '0; op3 = '0;
        drive_inputs();

        // reset state with every requester valid
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        check("rst_rsp", 32'({rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_overflow}), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive_inputs();
        rst_n = 1'b1; rst3_n = 1'b1;

        // single request: slot 2, 0xFF + 0xFF
        new_req(2, 8'hFF, 8'hFF, OP_ADD);
        drive_inputs();
        run_until_quiet(20);
        check("single_op_count", 32'(op_count), 32'd1);
        check("single_result", 32'({rsp_id, rsp_result, rsp_carry, rsp_zero}), 32'({2'd2, 8'hFE, 1'b1, 1'b0}));

        // only requester 3 valid: moves ptr across the wrap point
        new_req(3, 8'h80, 8'h80, OP_ADD);
        drive_inputs();
        run_until_quiet(20);

        // requesters 0 and 3 together must grant 0, then full rotation
        new_req(0, 8'h05, 8'h03, OP_SUB);
        new_req(3, 8'h03, 8'h05, OP_SUB);
        drive_inputs();
        rr_mode  = 1'b1;
        last_acc = -1;
        @(negedge clk);
        check("wrap_grant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        pend[0] = 1'b0;
        rand_en = 1'b1; rand_pct = 100;
        for (int i = 0; i < N; i++) if (!pend[i]) new_req(i, 8'($urandom), 8'($urandom), 2'($urandom));
        drive_inputs();
        n = 0;
        while (rr_ids.size() < 5 && n < 40) begin step(); n++; end
        rand_en = 1'b0;
        rr_mode = 1'b0;
        check("rr_count", 32'(rr_ids.size()), 32'd5);
        for (int i = 0; i < 5 && i < rr_ids.size(); i++) check("rr_seq", 32'(rr_ids[i]), 32'(exp_seq[i]));
        run_until_quiet(40);

        // backpressure: response held 10 cycles with others requesting
        rsp_ready = 1'b0;
        new_req(1, 8'hAA, 8'h55, OP_AND);
        drive_inputs();
        n = 0;
        while (!rsp_valid && n < 20) begin step(); n++; end
        new_req(0, 8'h01, 8'h02, OP_OR);
        new_req(2, 8'h7F, 8'h01, OP_ADD);
        new_req(3, 8'h00, 8'h01, OP_SUB);
        drive_inputs();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", 32'({rsp_valid, rsp_id, rsp_result, rsp_zero}), 32'({1'b1, 2'd1, 8'h00, 1'b1}));
            check("bp_no_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        run_until_quiet(60);

        // op_count wrap via forced preload while idle
        force dut.op_count_q = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        @(posedge clk); #1;
        release dut.op_count_q;
        new_req(1, 8'h01, 8'h01, OP_ADD);
        drive_inputs();
        run_until_quiet(20);
        check("cnt_wrap", 32'(op_count), 32'd0);

        // randomized traffic with random backpressure
        rand_en = 1'b1; rand_pct = 30; rand_rdy = 1'b1;
        repeat (400) step();
        rand_en = 1'b0; rand_rdy = 1'b0; rsp_ready = 1'b1;
        run_until_quiet(200);
        check("scoreboard_empty", 32'(q.size()), 32'd0);

        // reset in the second WAIT cycle of the ALU_LAT=3 instance
        a3  = {8'h44, 8'h33, 8'h12, 8'h81};
        b3  = {8'h04, 8'h03, 8'h34, 8'h7F};
        op3 = {OP_OR, OP_AND, OP_ADD, OP_SUB};
        v3  = 4'b0100;
        @(negedge clk);
        check("r3_grant", 32'(rdy3), 32'b0100);
        @(posedge clk); #1;
        v3 = '0;
        @(negedge clk);
        check("r3_busy", 32'({busy3, rsp3_valid}), 32'b10);
        @(posedge clk); #2;
        rst3_n = 1'b0;
        v3 = '1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("r3_rst_ready", 32'(rdy3), 32'd0);
            check("r3_rst_rsp", 32'({rsp3_valid, rsp3_id, rsp3_result, rsp3_carry, rsp3_zero, rsp3_overflow}), 32'd0);
            check("r3_rst_misc", 32'({busy3, op_count3, alu3_a, alu3_op}), 32'd0);
            check("r3_rst_alu_b", 32'(alu3_b), 32'd0);
        end
        @(posedge clk); #1;
        rst3_n = 1'b1;
        @(negedge clk);
        check("r3_first_grant", 32'(rdy3), 32'b0001);
        @(posedge clk); #1;
        v3 = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp3_valid && n < 10);
        r3 = alu_ref(8'h81, 8'h7F, OP_SUB);
        check("r3_latency", 32'(n), 32'(LAT3 + 1));
        check("r3_rsp", 32'({rsp3_id, rsp3_result, rsp3_carry, rsp3_zero, rsp3_overflow}),
              32'({2'd0, r3.r, r3.c, r3.z, r3.v}));
        @(negedge clk);
        check("r3_op_count", 32'(op_count3), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
